// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix frame loader: FSM states,
// error codes and the default dimension limit.
package matrix_pkg;

   localparam int unsigned MAX_DIM_DEFAULT = 32;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SHORT = 2'd1;
   localparam logic [1:0] ERR_DIM   = 2'd2;
   localparam logic [1:0] ERR_COUNT = 2'd3;

   typedef enum logic [3:0] {
      IDLE,
      RD_ROWS,
      RD_COLS,
      CHECK,
      FETCH,
      LOAD,
      SEND,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/matrix_frame_loader.sv
// Reads rows, cols and row-major elements from the number RAM, validates the
// header against the stored count and streams elements with row/col indices.
module matrix_frame_loader
   import matrix_pkg::*;
#(
   parameter int unsigned MAX_DIM    = MAX_DIM_DEFAULT,
   parameter int unsigned DIM_W      = 6,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  start,
   input  logic [10:0]           num_count,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] elem_data,
   output logic [DIM_W-1:0]      elem_row,
   output logic [DIM_W-1:0]      elem_col,
   output logic                  elem_valid,
   output logic                  elem_last,
   input  logic                  elem_ready,
   output logic [DIM_W-1:0]      mat_rows,
   output logic [DIM_W-1:0]      mat_cols,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code
);

   localparam int unsigned CMP_W = 12;
   localparam logic signed [DATA_WIDTH-1:0] LP_ONE = DATA_WIDTH'(1);
   localparam logic signed [DATA_WIDTH-1:0] LP_MAX = DATA_WIDTH'(MAX_DIM);

   state_t                r_state, w_next;
   logic [10:0]           r_count;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_rows;
   logic [DIM_W-1:0]      r_mat_rows, r_mat_cols;
   logic [DIM_W-1:0]      r_row, r_col;
   logic [DATA_WIDTH-1:0] r_elem_data;
   logic [DIM_W-1:0]      r_elem_row, r_elem_col;
   logic                  r_last;
   logic [1:0]            r_err_code;
   logic [1:0]            w_chk;
   logic                  w_rows_bad, w_cols_bad, w_hs;
   logic [2*DIM_W-1:0]    w_prod;
   logic [CMP_W-1:0]      w_need;

   // Header check runs in CHECK, where rd_data carries the column count.
   always_comb begin
      w_rows_bad = ($signed(r_rows) < LP_ONE) || ($signed(r_rows) > LP_MAX);
      w_cols_bad = ($signed(rd_data) < LP_ONE) || ($signed(rd_data) > LP_MAX);
      w_prod     = {{DIM_W{1'b0}}, r_rows[DIM_W-1:0]} * {{DIM_W{1'b0}}, rd_data[DIM_W-1:0]};
      w_need     = CMP_W'(w_prod) + CMP_W'(2);
      w_chk      = ERR_NONE;
      if (r_count < 11'd3)
         w_chk = ERR_SHORT;
      else if (w_rows_bad || w_cols_bad)
         w_chk = ERR_DIM;
      else if (w_need != CMP_W'(r_count))
         w_chk = ERR_COUNT;
   end

   assign w_hs = (r_state == SEND) && elem_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, ERROR: if (start) w_next = RD_ROWS;
         RD_ROWS:           w_next = RD_COLS;
         RD_COLS:           w_next = CHECK;
         CHECK:             w_next = (w_chk != ERR_NONE) ? ERROR : FETCH;
         FETCH:             w_next = LOAD;
         LOAD:              w_next = SEND;
         SEND:              if (w_hs) w_next = r_last ? DONE : FETCH;
         default:           w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_count     <= '0;
         r_addr      <= '0;
         r_rows      <= '0;
         r_mat_rows  <= '0;
         r_mat_cols  <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_elem_data <= '0;
         r_elem_row  <= '0;
         r_elem_col  <= '0;
         r_last      <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         case (r_state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  r_count    <= num_count;
                  r_addr     <= '0;
                  r_err_code <= ERR_NONE;
               end
            end
            RD_ROWS: r_addr <= ADDR_WIDTH'(1);
            RD_COLS: begin
               r_rows     <= rd_data;
               r_mat_rows <= rd_data[DIM_W-1:0];
            end
            CHECK: begin
               r_mat_cols <= rd_data[DIM_W-1:0];
               if (w_chk != ERR_NONE) begin
                  r_err_code <= w_chk;
               end else begin
                  r_addr <= ADDR_WIDTH'(2);
                  r_row  <= '0;
                  r_col  <= '0;
               end
            end
            LOAD: begin
               r_elem_data <= rd_data;
               r_elem_row  <= r_row;
               r_elem_col  <= r_col;
               r_last      <= (r_row == r_mat_rows - DIM_W'(1)) &&
                              (r_col == r_mat_cols - DIM_W'(1));
            end
            SEND: begin
               if (w_hs && !r_last) begin
                  if (r_col == r_mat_cols - DIM_W'(1)) begin
                     r_col <= '0;
                     r_row <= r_row + DIM_W'(1);
                  end else begin
                     r_col <= r_col + DIM_W'(1);
                  end
                  r_addr <= r_addr + ADDR_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_addr    = r_addr;
   assign elem_data  = r_elem_data;
   assign elem_row   = r_elem_row;
   assign elem_col   = r_elem_col;
   assign elem_last  = r_last;
   assign elem_valid = (r_state == SEND);
   assign mat_rows   = r_mat_rows;
   assign mat_cols   = r_mat_cols;
   assign busy       = (r_state != IDLE) && (r_state != DONE) && (r_state != ERROR);
   assign done       = (r_state == DONE);
   assign error      = (r_state == ERROR);
   assign err_code   = r_err_code;

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Bench for matrix_frame_loader: RAM model, element scoreboard, case table
// and hand-written sequences for clear, reset and restart behaviour.
module tb_matrix_frame_loader;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        start;
   logic [10:0] num_count;
   logic [10:0] rd_addr;
   logic [31:0] rd_data;
   logic [31:0] elem_data;
   logic [5:0]  elem_row;
   logic [5:0]  elem_col;
   logic        elem_valid;
   logic        elem_last;
   logic        elem_ready;
   logic [5:0]  mat_rows;
   logic [5:0]  mat_cols;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;

   matrix_frame_loader #(
      .MAX_DIM    (32),
      .DIM_W      (6),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (11)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .start      (start),
      .num_count  (num_count),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .elem_data  (elem_data),
      .elem_row   (elem_row),
      .elem_col   (elem_col),
      .elem_valid (elem_valid),
      .elem_last  (elem_last),
      .elem_ready (elem_ready),
      .mat_rows   (mat_rows),
      .mat_cols   (mat_cols),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [5:0]  r;
      logic [5:0]  c;
      logic        l;
   } elem_t;

   typedef struct {
      int rows;
      int cols;
      int cnt;
      int base;
      int code;
      bit rnd;
   } vec_t;

   logic [31:0] ram [0:2047];
   elem_t       exp_q [$];
   int          hs_q [$];
   int          cyc = 0;
   int          vcnt;
   int          total = 0;
   int          bad = 0;
   int          ready_mode = 1;
   bit          stall_prev = 0;
   logic [45:0] held;
   vec_t        tbl [10];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_data <= ram[rd_addr];
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      elem_t e;
      if (stall_prev)
         chk("stall_hold", {elem_valid, elem_data, elem_row, elem_col, elem_last}, held);
      if (elem_valid) vcnt++;
      if (elem_valid && elem_ready) begin
         hs_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_elem actual=(%0d,%0d)=%0d required=none", elem_row, elem_col, $signed(elem_data));
         end else begin
            e = exp_q.pop_front();
            chk("elem_data", elem_data, e.d);
            chk("elem_row",  elem_row,  e.r);
            chk("elem_col",  elem_col,  e.c);
            chk("elem_last", elem_last, e.l);
         end
      end
      stall_prev = elem_valid && !elem_ready && !clear && rst_n;
      held       = {elem_valid, elem_data, elem_row, elem_col, elem_last};
   endtask

   // Sample at the falling edge, drive just after the rising edge.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       elem_ready = 1'b0;
         2:       elem_ready = 1'($urandom_range(0, 1));
         default: elem_ready = 1'b1;
      endcase
   endtask

   task automatic kick(input int rows, input int cols, input int cnt, input int base,
                       input int code, input bit rnd, output int t0);
      ram[0] = rows;
      ram[1] = cols;
      for (int i = 0; i < cnt - 2 && i < 2046; i++) ram[2 + i] = base + i;
      if (code == 0)
         for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
               exp_q.push_back('{d: 32'(base + r * cols + c), r: 6'(r), c: 6'(c),
                                 l: (r == rows - 1) && (c == cols - 1)});
      hs_q.delete();
      vcnt       = 0;
      ready_mode = rnd ? 2 : 1;
      num_count  = 11'(cnt);
      start      = 1'b1;
      t0         = cyc;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_end(output int tend);
      tend = -1;
      for (int n = 0; n < 5000; n++) begin
         if (done || error) begin
            tend = cyc;
            break;
         end
         step();
      end
      chk("end_reached", tend >= 0, 1);
   endtask

   task automatic run_case(input vec_t v, output int t0, output int tend);
      kick(v.rows, v.cols, v.cnt, v.base, v.code, v.rnd, t0);
      chk("busy_c1", busy, 1);
      chk("addr_c1", rd_addr, 0);
      step();
      chk("addr_c2", rd_addr, 1);
      wait_end(tend);
      chk("done",     done,     v.code == 0);
      chk("error",    error,    v.code != 0);
      chk("err_code", err_code, v.code);
      chk("busy_end", busy,     0);
      if (v.code != 0) begin
         chk("err_cycle", tend - t0, 4);
         chk("no_valid",  vcnt,      0);
      end else begin
         chk("sb_empty",   exp_q.size(), 0);
         chk("elem_count", hs_q.size(),  v.rows * v.cols);
         chk("mat_rows",   mat_rows,     v.rows);
         chk("mat_cols",   mat_cols,     v.cols);
      end
   endtask

   initial begin
      int   t0, tend;
      vec_t v;

      tbl[0] = '{rows: 2,  cols: 3,  cnt: 8,    base: 1,   code: 0, rnd: 1};
      tbl[1] = '{rows: 0,  cols: 4,  cnt: 2,    base: 0,   code: 1, rnd: 0};
      tbl[2] = '{rows: 33, cols: 1,  cnt: 35,   base: 0,   code: 2, rnd: 0};
      tbl[3] = '{rows: -1, cols: 2,  cnt: 3,    base: 0,   code: 2, rnd: 0};
      tbl[4] = '{rows: 2,  cols: 2,  cnt: 5,    base: 0,   code: 3, rnd: 0};
      tbl[5] = '{rows: 3,  cols: 33, cnt: 101,  base: 0,   code: 2, rnd: 0};
      tbl[6] = '{rows: 2,  cols: 3,  cnt: 7,    base: 0,   code: 3, rnd: 0};
      tbl[7] = '{rows: 1,  cols: 32, cnt: 34,   base: 100, code: 0, rnd: 1};
      tbl[8] = '{rows: 32, cols: 32, cnt: 1026, base: -500, code: 0, rnd: 0};
      tbl[9] = '{rows: 1,  cols: 1,  cnt: 3,    base: 42,  code: 0, rnd: 1};

      rst_n      = 1'b0;
      clear      = 1'b0;
      start      = 1'b0;
      num_count  = '0;
      elem_ready = 1'b0;
      for (int i = 0; i < 2048; i++) ram[i] = '0;
      repeat (3) step();
      chk("reset_dp",  {rd_addr, elem_data, elem_row, elem_col, mat_rows, mat_cols}, 0);
      chk("reset_ctl", {elem_valid, elem_last, busy, done, error, err_code}, 0);
      rst_n = 1'b1;
      step();
      chk("idle_ctl", {elem_valid, busy, done, error, err_code}, 0);

      // Basic frame with cycle-exact timing.
      v = '{rows: 2, cols: 3, cnt: 8, base: 1, code: 0, rnd: 0};
      run_case(v, t0, tend);
      for (int i = 0; i < 6; i++)
         if (hs_q.size() > i) chk("hs_cycle", hs_q[i] - t0, 6 + 3 * i);
      chk("done_cycle",     tend - t0,  22);
      chk("valid_at_done",  elem_valid, 0);

      for (int i = 0; i < 10; i++) run_case(tbl[i], t0, tend);

      // Clear during SEND of the third element.
      kick(2, 3, 8, 1, 0, 0, t0);
      for (int n = 0; n < 100 && hs_q.size() < 2; n++) step();
      ready_mode = 0;
      elem_ready = 1'b0;
      for (int n = 0; n < 20 && !elem_valid; n++) step();
      chk("sent_before_clear", hs_q.size(), 2);
      chk("valid_before_clear", elem_valid, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_dp",  {rd_addr, elem_data, elem_row, elem_col, mat_rows, mat_cols}, 0);
      chk("clear_ctl", {elem_valid, elem_last, busy, done, error, err_code}, 0);
      chk("clear_hs",  hs_q.size(), 2);
      exp_q.delete();
      v = '{rows: 2, cols: 3, cnt: 8, base: 1, code: 0, rnd: 0};
      run_case(v, t0, tend);

      // Reset mid-frame behaves like clear.
      kick(2, 2, 6, 9, 0, 0, t0);
      repeat (7) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_mid_dp",  {rd_addr, elem_data, elem_row, elem_col, mat_rows, mat_cols}, 0);
      chk("rst_mid_ctl", {elem_valid, elem_last, busy, done, error, err_code}, 0);
      exp_q.delete();
      step();

      // start pulsed during FETCH is ignored.
      kick(2, 3, 8, 1, 0, 0, t0);
      repeat (3) step();
      chk("fetch_busy", busy, 1);
      start     = 1'b1;
      num_count = 11'd3;
      step();
      start     = 1'b0;
      num_count = 11'd8;
      wait_end(tend);
      chk("ign_done",  done,         1);
      chk("ign_error", error,        0);
      chk("ign_count", hs_q.size(),  6);
      chk("ign_empty", exp_q.size(), 0);

      // Restart from DONE with a single negative element.
      v = '{rows: 1, cols: 1, cnt: 3, base: -7, code: 0, rnd: 0};
      run_case(v, t0, tend);
      chk("single_cycle", tend - t0, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
